bomb_controller: RTL and testbench

- Single-bomb placement, fuse timing and explosion block for the Bomberman game.
- Takes the player position and the debounced centre button, and places a bomb on the player's tile.
- Runs the fuse, then a cross-shaped explosion clipped by pillars and grid edges.
- Produces per-pixel bomb/explosion enables and colours for the top-level RGB priority mux, plus tile/status outputs for collision logic.

---
 rtl/bomb_controller.sv | 211 +++++++++++++++++++++
 tb/tb_bomb_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_controller.sv
// Single-bomb placement, fuse timer and cross-shaped explosion for the Bomberman playfield.
// Produces registered per-pixel bomb/explosion enables and colours plus bomb tile/status.
module bomb_controller #(
  parameter int TILE_SHIFT     = 5,
  parameter int GRID_W         = 20,
  parameter int GRID_H         = 15,
  parameter int FUSE_CYCLES    = 200_000_000,
  parameter int EXPLODE_CYCLES = 50_000_000,
  parameter int RANGE          = 2,
  parameter int BLINK_SHIFT    = 22
) (
  input  logic        sys_clk,
  input  logic        Reset,
  input  logic        place,
  input  logic        game_over,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  output logic        bomb_rgb_en,
  output logic [11:0] bomb_rgb,
  output logic        explosion_rgb_en,
  output logic [11:0] explosion_rgb,
  output logic        bomb_active,
  output logic        exploding,
  output logic [4:0]  bomb_tx,
  output logic [4:0]  bomb_ty
);

  localparam int CNT_W = 32;
  localparam int TILE  = 1 << TILE_SHIFT;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPLODE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             place_q_r;
  logic [5:0]       l_left_r, l_right_r, l_up_r, l_down_r;

  // Arm stops before the first tile that is off-grid or a pillar (odd x and odd y).
  function automatic logic [5:0] arm_len(input logic [5:0] tx, input logic [5:0] ty,
                                         input int dx, input int dy);
    logic [5:0] len;
    logic       blocked;
    int         x, y;
    len     = 6'd0;
    blocked = 1'b0;
    for (int k = 1; k <= RANGE; k++) begin
      x = int'(tx) + dx * k;
      y = int'(ty) + dy * k;
      if (blocked || x < 0 || x >= GRID_W || y < 0 || y >= GRID_H || (x[0] && y[0]))
        blocked = 1'b1;
      else
        len = 6'(k);
    end
    return len;
  endfunction

  logic [10:0] cx_s, cy_s;
  logic [5:0]  ptx_raw_s, pty_raw_s;
  logic [4:0]  ptx_s, pty_s;
  logic        rise_s, fuse_done_s, explode_done_s;
  logic [5:0]  btx6_s, bty6_s;
  logic [5:0]  len_left_s, len_right_s, len_up_s, len_down_s;

  // Placement tile uses the sprite centre, clamped to the playfield.
  assign cx_s      = {1'b0, b_x} + 11'(TILE / 2);
  assign cy_s      = {1'b0, b_y} + 11'(TILE / 2);
  assign ptx_raw_s = 6'(cx_s >> TILE_SHIFT);
  assign pty_raw_s = 6'(cy_s >> TILE_SHIFT);
  assign ptx_s     = (ptx_raw_s > 6'(GRID_W - 1)) ? 5'(GRID_W - 1) : ptx_raw_s[4:0];
  assign pty_s     = (pty_raw_s > 6'(GRID_H - 1)) ? 5'(GRID_H - 1) : pty_raw_s[4:0];

  assign rise_s         = place & ~place_q_r;
  assign fuse_done_s    = (cnt_r == CNT_W'(FUSE_CYCLES - 1));
  assign explode_done_s = (cnt_r == CNT_W'(EXPLODE_CYCLES - 1));

  assign btx6_s      = {1'b0, bomb_tx};
  assign bty6_s      = {1'b0, bomb_ty};
  assign len_left_s  = arm_len(btx6_s, bty6_s, -1, 0);
  assign len_right_s = arm_len(btx6_s, bty6_s, 1, 0);
  assign len_up_s    = arm_len(btx6_s, bty6_s, 0, -1);
  assign len_down_s  = arm_len(btx6_s, bty6_s, 0, 1);

  // Bomb lifecycle FSM with its counter, latched tile, arm lengths and status outputs.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      place_q_r   <= 1'b0;
      bomb_active <= 1'b0;
      exploding   <= 1'b0;
      bomb_tx     <= 5'd0;
      bomb_ty     <= 5'd0;
      l_left_r    <= 6'd0;
      l_right_r   <= 6'd0;
      l_up_r      <= 6'd0;
      l_down_r    <= 6'd0;
    end else begin
      place_q_r <= place;
      if (game_over) begin
        state_r     <= IDLE;
        cnt_r       <= {CNT_W{1'b0}};
        bomb_active <= 1'b0;
        exploding   <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (rise_s) begin
              state_r     <= ARMED;
              cnt_r       <= {CNT_W{1'b0}};
              bomb_tx     <= ptx_s;
              bomb_ty     <= pty_s;
              bomb_active <= 1'b1;
            end
          end
          ARMED: begin
            if (fuse_done_s) begin
              state_r   <= EXPLODE;
              cnt_r     <= {CNT_W{1'b0}};
              exploding <= 1'b1;
              l_left_r  <= len_left_s;
              l_right_r <= len_right_s;
              l_up_r    <= len_up_s;
              l_down_r  <= len_down_s;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          EXPLODE: begin
            if (explode_done_s) begin
              state_r     <= IDLE;
              cnt_r       <= {CNT_W{1'b0}};
              bomb_active <= 1'b0;
              exploding   <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bomb_active <= 1'b0;
            exploding   <= 1'b0;
          end
        endcase
      end
    end
  end

  logic [5:0]            pix_tx_s, pix_ty_s;
  logic [TILE_SHIFT-1:0] off_x_s, off_y_s;
  logic                  in_grid_s, centre_s, off_ok_s, row_hit_s, col_hit_s, blink_s;
  logic                  bomb_en_s, exp_en_s;
  logic [11:0]           bomb_col_s, exp_col_s;

  assign pix_tx_s  = 6'(v_x >> TILE_SHIFT);
  assign pix_ty_s  = 6'(v_y >> TILE_SHIFT);
  assign off_x_s   = v_x[TILE_SHIFT-1:0];
  assign off_y_s   = v_y[TILE_SHIFT-1:0];
  assign in_grid_s = (pix_tx_s < 6'(GRID_W)) && (pix_ty_s < 6'(GRID_H));
  assign centre_s  = (pix_tx_s == btx6_s) && (pix_ty_s == bty6_s);
  assign off_ok_s  = (off_x_s >= TILE_SHIFT'(4)) && (off_x_s <= TILE_SHIFT'(TILE - 5)) &&
                     (off_y_s >= TILE_SHIFT'(4)) && (off_y_s <= TILE_SHIFT'(TILE - 5));
  // Arm lengths were clipped at the grid edge, so the subtractions cannot wrap.
  assign row_hit_s = (pix_ty_s == bty6_s) && (pix_tx_s >= btx6_s - l_left_r) &&
                     (pix_tx_s <= btx6_s + l_right_r);
  assign col_hit_s = (pix_tx_s == btx6_s) && (pix_ty_s >= bty6_s - l_up_r) &&
                     (pix_ty_s <= bty6_s + l_down_r);
  assign blink_s   = (cnt_r >= CNT_W'(FUSE_CYCLES - FUSE_CYCLES / 4)) && cnt_r[BLINK_SHIFT];

  // Next-pixel enables and colours; bomb and explosion are mutually exclusive by state.
  always_comb begin
    bomb_en_s  = 1'b0;
    bomb_col_s = 12'h000;
    exp_en_s   = 1'b0;
    exp_col_s  = 12'h000;
    if (!game_over && in_grid_s && state_r == ARMED && centre_s && off_ok_s) begin
      bomb_en_s = 1'b1;
      if (blink_s) bomb_col_s = 12'hF00;
      else         bomb_col_s = 12'h222;
    end else if (!game_over && in_grid_s && state_r == EXPLODE && (row_hit_s || col_hit_s)) begin
      exp_en_s = 1'b1;
      if (centre_s) exp_col_s = 12'hFA0;
      else          exp_col_s = 12'hF50;
    end else begin
      bomb_en_s = 1'b0;
      exp_en_s  = 1'b0;
    end
  end

  // One-cycle registered pixel outputs.
  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      bomb_rgb_en      <= 1'b0;
      bomb_rgb         <= 12'h000;
      explosion_rgb_en <= 1'b0;
      explosion_rgb    <= 12'h000;
    end else begin
      bomb_rgb_en      <= bomb_en_s;
      bomb_rgb         <= bomb_col_s;
      explosion_rgb_en <= exp_en_s;
      explosion_rgb    <= exp_col_s;
    end
  end

endmodule

// File: tb/tb_bomb_controller.sv
// Directed self-checking bench for bomb_controller with a short fuse (10) and explosion (4).
module tb_bomb_controller;

  logic        sys_clk = 1'b0;
  logic        Reset, place, game_over;
  logic [9:0]  b_x, b_y, v_x, v_y;
  logic        bomb_rgb_en, explosion_rgb_en, bomb_active, exploding;
  logic [11:0] bomb_rgb, explosion_rgb;
  logic [4:0]  bomb_tx, bomb_ty;

  int n_checks = 0;
  int n_fail   = 0;

  bomb_controller #(
    .FUSE_CYCLES(10), .EXPLODE_CYCLES(4), .BLINK_SHIFT(0)
  ) dut (
    .sys_clk(sys_clk), .Reset(Reset), .place(place), .game_over(game_over),
    .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
    .bomb_rgb_en(bomb_rgb_en), .bomb_rgb(bomb_rgb),
    .explosion_rgb_en(explosion_rgb_en), .explosion_rgb(explosion_rgb),
    .bomb_active(bomb_active), .exploding(exploding),
    .bomb_tx(bomb_tx), .bomb_ty(bomb_ty)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic place_bomb(input logic [9:0] bx, input logic [9:0] by);
    b_x = bx; b_y = by; place = 1'b0;
    tick;
    place = 1'b1;
    tick;
    place = 1'b0;
  endtask

  task automatic wait_explode(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (exploding === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 30; i++) begin
      if (bomb_active === 1'b0) break;
      tick;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; place = 1'b0; game_over = 1'b0;
    b_x = 10'd0; b_y = 10'd0; v_x = 10'd0; v_y = 10'd0;
    tick; tick;
    Reset = 1'b0;
    tick;
    n_checks++;
    if ({bomb_active, exploding, bomb_rgb_en, explosion_rgb_en} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bomb_active, exploding, bomb_rgb_en, explosion_rgb_en});
    end
    n_checks++;
    if ({bomb_tx, bomb_ty, bomb_rgb, explosion_rgb} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {bomb_tx, bomb_ty, bomb_rgb, explosion_rgb});
    end
  endtask

  task automatic test_fuse_timing;
    logic [29:0] exp_v, got_v;
    v_x = 10'd74; v_y = 10'd74;
    place_bomb(10'd48, 10'd48);
    n_checks++;
    if ({bomb_active, exploding, bomb_tx, bomb_ty} !== {1'b1, 1'b0, 5'd2, 5'd2}) begin
      n_fail++;
      $display("FAIL fuse_place: got act=%b exp=%b tx=%0d ty=%0d expected act=1 exp=0 tx=2 ty=2",
               bomb_active, exploding, bomb_tx, bomb_ty);
    end
    for (int i = 1; i <= 15; i++) begin
      tick;
      exp_v[29]    = (i <= 13);
      exp_v[28]    = (i >= 10 && i <= 13);
      exp_v[27]    = (i <= 10);
      exp_v[26]    = (i >= 11 && i <= 14);
      exp_v[25:24] = 2'b00;
      exp_v[23:12] = (i == 10) ? 12'hF00 : ((i <= 10) ? 12'h222 : 12'h000);
      exp_v[11:0]  = (i >= 11 && i <= 14) ? 12'hFA0 : 12'h000;
      got_v = {bomb_active, exploding, bomb_rgb_en, explosion_rgb_en, 2'b00, bomb_rgb, explosion_rgb};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL fuse_cycle_%0d: got %h expected %h", i, got_v, exp_v);
      end
    end
  endtask

  typedef struct {
    logic [9:0]  bx, by;
    logic [4:0]  tx, ty;
    logic [9:0]  vx, vy;
    logic        en;
    logic [11:0] rgb;
  } vec_t;

  task automatic test_arms;
    vec_t vecs[17];
    int   n;
    vecs = '{
      '{10'd48,   10'd48,   5'd2,  5'd2,  10'd130, 10'd70,  1'b1, 12'hF50},
      '{10'd48,   10'd48,   5'd2,  5'd2,  10'd170, 10'd70,  1'b0, 12'h000},
      '{10'd48,   10'd48,   5'd2,  5'd2,  10'd5,   10'd70,  1'b1, 12'hF50},
      '{10'd48,   10'd48,   5'd2,  5'd2,  10'd70,  10'd5,   1'b1, 12'hF50},
      '{10'd48,   10'd48,   5'd2,  5'd2,  10'd70,  10'd150, 1'b1, 12'hF50},
      '{10'd48,   10'd48,   5'd2,  5'd2,  10'd70,  10'd170, 1'b0, 12'h000},
      '{10'd48,   10'd48,   5'd2,  5'd2,  10'd100, 10'd100, 1'b0, 12'h000},
      '{10'd48,   10'd48,   5'd2,  5'd2,  10'd70,  10'd70,  1'b1, 12'hFA0},
      '{10'd0,    10'd32,   5'd0,  5'd1,  10'd5,   10'd5,   1'b1, 12'hF50},
      '{10'd0,    10'd32,   5'd0,  5'd1,  10'd5,   10'd70,  1'b1, 12'hF50},
      '{10'd0,    10'd32,   5'd0,  5'd1,  10'd5,   10'd100, 1'b1, 12'hF50},
      '{10'd0,    10'd32,   5'd0,  5'd1,  10'd5,   10'd130, 1'b0, 12'h000},
      '{10'd0,    10'd32,   5'd0,  5'd1,  10'd40,  10'd40,  1'b0, 12'h000},
      '{10'd1000, 10'd1000, 5'd19, 5'd14, 10'd549, 10'd453, 1'b1, 12'hF50},
      '{10'd1000, 10'd1000, 5'd19, 5'd14, 10'd645, 10'd453, 1'b0, 12'h000},
      '{10'd1000, 10'd1000, 5'd19, 5'd14, 10'd613, 10'd421, 1'b0, 12'h000},
      '{10'd16,   10'd48,   5'd1,  5'd2,  10'd5,   10'd70,  1'b1, 12'hF50}
    };
    foreach (vecs[k]) begin
      v_x = 10'd0; v_y = 10'd0;
      place_bomb(vecs[k].bx, vecs[k].by);
      n_checks++;
      if ({bomb_tx, bomb_ty} !== {vecs[k].tx, vecs[k].ty}) begin
        n_fail++;
        $display("FAIL arms_tile_%0d: got (%0d,%0d) expected (%0d,%0d)",
                 k, bomb_tx, bomb_ty, vecs[k].tx, vecs[k].ty);
      end
      wait_explode(n);
      n_checks++;
      if (n != 10) begin
        n_fail++;
        $display("FAIL arms_fuse_%0d: got %0d cycles expected 10", k, n);
      end
      v_x = vecs[k].vx; v_y = vecs[k].vy;
      tick;
      n_checks++;
      if ({explosion_rgb_en, explosion_rgb, bomb_rgb_en} !== {vecs[k].en, vecs[k].rgb, 1'b0}) begin
        n_fail++;
        $display("FAIL arms_pix_%0d: got en=%b rgb=%h bomb_en=%b expected en=%b rgb=%h bomb_en=0",
                 k, explosion_rgb_en, explosion_rgb, bomb_rgb_en, vecs[k].en, vecs[k].rgb);
      end
      wait_idle;
    end
  endtask

  task automatic test_hold;
    int rises;
    logic prev;
    rises = 0; prev = bomb_active;
    b_x = 10'd48; b_y = 10'd48; place = 1'b0;
    tick;
    place = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (bomb_active === 1'b1 && prev === 1'b0) rises++;
      prev = bomb_active;
    end
    place = 1'b0;
    n_checks++;
    if (rises != 1) begin
      n_fail++;
      $display("FAIL hold_rises: got %0d expected 1", rises);
    end
    n_checks++;
    if (bomb_active !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_final: got %b expected 0", bomb_active);
    end
  endtask

  task automatic test_back_to_back;
    place_bomb(10'd48, 10'd48);
    tick; tick; tick;
    b_x = 10'd200; b_y = 10'd200; place = 1'b1;
    tick;
    place = 1'b0;
    n_checks++;
    if ({bomb_tx, bomb_ty} !== {5'd2, 5'd2}) begin
      n_fail++;
      $display("FAIL rearm_tile: got (%0d,%0d) expected (2,2)", bomb_tx, bomb_ty);
    end
    for (int i = 5; i <= 10; i++) begin
      tick;
      n_checks++;
      if (exploding !== (i == 10)) begin
        n_fail++;
        $display("FAIL rearm_count_%0d: got %b expected %b", i, exploding, (i == 10));
      end
    end
    place = 1'b1;
    tick;
    place = 1'b0;
    for (int i = 0; i < 12; i++) tick;
    n_checks++;
    if (bomb_active !== 1'b0) begin
      n_fail++;
      $display("FAIL explode_rise_ignored: got %b expected 0", bomb_active);
    end
  endtask

  task automatic test_game_over;
    v_x = 10'd74; v_y = 10'd74;
    place_bomb(10'd48, 10'd48);
    tick; tick;
    game_over = 1'b1;
    tick;
    n_checks++;
    if ({bomb_active, exploding, bomb_rgb_en, explosion_rgb_en} !== 4'b0000) begin
      n_fail++;
      $display("FAIL gameover_idle: got %b expected 0000",
               {bomb_active, exploding, bomb_rgb_en, explosion_rgb_en});
    end
    place = 1'b1;
    tick;
    place = 1'b0;
    tick;
    n_checks++;
    if ({bomb_active, bomb_rgb_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL gameover_block: got %b expected 00", {bomb_active, bomb_rgb_en});
    end
    game_over = 1'b0;
    tick; tick;
    n_checks++;
    if (bomb_active !== 1'b0) begin
      n_fail++;
      $display("FAIL gameover_release: got %b expected 0", bomb_active);
    end
  endtask

  task automatic test_reset_mid_explode;
    int n;
    v_x = 10'd70; v_y = 10'd70;
    place_bomb(10'd48, 10'd48);
    wait_explode(n);
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({bomb_active, exploding, bomb_rgb_en, explosion_rgb_en, bomb_tx, bomb_ty, explosion_rgb}
        !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_mid_explode: got act=%b exp=%b een=%b tx=%0d rgb=%h expected all 0",
               bomb_active, exploding, explosion_rgb_en, bomb_tx, explosion_rgb);
    end
    tick;
    Reset = 1'b0;
    tick;
    place_bomb(10'd48, 10'd48);
    wait_explode(n);
    n_checks++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL reset_full_fuse: got %0d cycles expected 10", n);
    end
    wait_idle;
  endtask

  initial begin
    test_reset;
    test_fuse_timing;
    test_arms;
    test_hold;
    test_back_to_back;
    test_game_over;
    test_reset_mid_explode;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
